tt_tdc_pulse_gen: RTL and testbench
===================================

// Module: tt_tdc_pulse_gen
// PURPOSE
//   Programmable start/stop edge generator that stimulates the ring-oscillator TDC, which measures
//   the start-to-stop interval and outputs an 8-bit time count.
//   Emits a start rising edge, then a stop rising edge exactly D clk cycles later, repeated N times
//   with fixed idle gaps. Used for on-chip calibration and self-test of the TDC.
// PARAMETERS
//   CNT_W       8   width of delay field D and of the internal delay counter
//   PULSE_W     2   cycles stop_o stays high, with start_o still high, before both drop (>=1)
//   GAP_CYCLES  4   cycles both outputs stay low between measurements (>=1)
// PORTS
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   cfg_valid  in   1      configuration request
//   cfg_ready  out  1      block can accept configuration (= idle & ~abort)
//   cfg_delay  in   CNT_W  D: start-to-stop delay in clk cycles
//   cfg_count  in   8      N: measurements per burst; 0 treated as 1
//   abort      in   1      synchronous burst cancel
//   start_o    out  1      TDC start line (rising edge = start)
//   stop_o     out  1      TDC stop line (rising edge = stop)
//   busy       out  1      high whenever state != IDLE
//   done       out  1      one-cycle pulse after the last measurement's gap completes
//   seq_cnt    out  8      completed measurements in the current/last burst
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; start_o=0, stop_o=0, busy=0, done=0, seq_cnt=0,
//     all counters 0. Takes effect immediately, including mid-burst.
//   - All outputs are registered. cfg_ready is combinational from state and abort.
//   - Accept: cfg_valid & cfg_ready at clk edge k latches D and N (N:=1 if 0), clears seq_cnt,
//     and leaves IDLE. cfg_* are ignored while busy.
//   - FSM states:
//     IDLE -> ARM on accept.
//     ARM: start_o=1, stop_o=0. Counts D cycles, then -> FIRE.
//     FIRE: start_o=1, stop_o=1 for PULSE_W cycles, then -> GAP.
//     GAP: both 0 for GAP_CYCLES cycles. Then -> ARM if more measurements remain, else -> IDLE.
//   - Timing for one measurement, where edge s is the start edge (s = k+1 for the first):
//     start_o rises at edge s.
//     stop_o rises at edge s+D. D=0: stop_o rises at s, same edge as start_o (ARM skipped).
//     Both fall at s+D+PULSE_W.
//     Next start edge at s+D+PULSE_W+GAP_CYCLES.
//   - seq_cnt increments (saturating at 255) on the edge where start_o/stop_o fall.
//   - End of burst: final GAP ends -> IDLE; done=1 for exactly that one cycle; cfg_ready=1 in the
//     same cycle. A new accept then yields the next start edge one cycle later.
//   - abort=1 sampled in ARM/FIRE/GAP: next edge -> IDLE, both outputs 0, no done pulse,
//     seq_cnt holds. abort in IDLE has no effect other than forcing cfg_ready=0.
//     abort wins over a simultaneous accept.
//   - D counter is loaded per measurement and counts down to 0; no wrap-around possible.
//     D=2^CNT_W-1 is legal.
//   - stop_o never rises without start_o high. start_o never rises while stop_o is high.
// TESTING
//   1. D=5, N=1, accept at edge 0 -> start_o rises e1, stop_o rises e6, both fall e8,
//      done pulse e12, seq_cnt=1.
//   2. D=0, N=1 -> start_o and stop_o rise on the same edge e1, fall e3, done e7.
//   3. D=2, N=3 -> start edges at e1, e9, e17; stop edges at e3, e11, e19;
//      single done at e25; seq_cnt=3.
//   4. D=10, N=2, abort held high at edge 4 (ARM) -> at e5 start_o=0, busy=0, cfg_ready=1;
//      no done; seq_cnt=0.
//   5. rst_n low mid-FIRE (between clk edges) -> start_o, stop_o, busy drop immediately;
//      seq_cnt=0; block restarts cleanly.
//   6. cfg_count=0 -> one measurement. cfg_valid pulsed while busy -> ignored, cfg_ready=0,
//      latched D unchanged.

Source files
------------

// File: rtl/tt_tdc_pulse_gen.sv
// Start/stop edge generator for ring-oscillator TDC calibration: per measurement, start rises,
// stop follows D cycles later, both hold PULSE_W cycles, then a GAP_CYCLES idle gap; N times.
module tt_tdc_pulse_gen #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PULSE_W    = 2,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [7:0]       cfg_count,
  input  logic             abort,
  output logic             start_o,
  output logic             stop_o,
  output logic             busy,
  output logic             done,
  output logic [7:0]       seq_cnt
);

  localparam int unsigned TMAX = (PULSE_W > GAP_CYCLES) ? PULSE_W : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

  // LOAD is the single cycle between accept and the first start edge.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_FIRE,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dcfg_q, dcfg_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [7:0]       ncfg_q, ncfg_d;
  logic [7:0]       seq_q, seq_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             begin_meas;

  assign cfg_ready = (state_q == S_IDLE) & ~abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dcfg_q  <= '0;
      dly_q   <= '0;
      tmr_q   <= '0;
      ncfg_q  <= '0;
      seq_q   <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dcfg_q  <= dcfg_d;
      dly_q   <= dly_d;
      tmr_q   <= tmr_d;
      ncfg_q  <= ncfg_d;
      seq_q   <= seq_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dcfg_d     = dcfg_q;
    dly_d      = dly_q;
    tmr_d      = tmr_q;
    ncfg_d     = ncfg_q;
    seq_d      = seq_q;
    begin_meas = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          state_d = S_LOAD;
          dcfg_d  = cfg_delay;
          ncfg_d  = (cfg_count == 8'd0) ? 8'd1 : cfg_count;
          seq_d   = '0;
        end
      end
      S_LOAD: begin
        begin_meas = 1'b1;
      end
      S_ARM: begin
        if (dly_q == '0) begin
          state_d = S_FIRE;
          tmr_d   = PULSE_LD;
        end else begin
          dly_d = dly_q - CNT_W'(1);
        end
      end
      S_FIRE: begin
        if (tmr_q == '0) begin
          state_d = S_GAP;
          tmr_d   = GAP_LD;
          seq_d   = (seq_q == 8'hFF) ? seq_q : seq_q + 8'd1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == '0) begin
          if (seq_q == ncfg_q) begin
            state_d = S_IDLE;
          end else begin
            begin_meas = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // D=0 skips ARM so stop rises on the same edge as start.
    if (begin_meas) begin
      if (dcfg_q == '0) begin
        state_d = S_FIRE;
        tmr_d   = PULSE_LD;
      end else begin
        state_d = S_ARM;
        dly_d   = dcfg_q - CNT_W'(1);
      end
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      seq_d   = seq_q;
    end
  end

  always_comb begin
    start_d = (state_d == S_ARM) || (state_d == S_FIRE);
    stop_d  = (state_d == S_FIRE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_GAP) && (state_d == S_IDLE) && !abort;
  end

  assign start_o = start_q;
  assign stop_o  = stop_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign seq_cnt = seq_q;

endmodule

// File: tb/tb_tt_tdc_pulse_gen.sv
// Bench for tt_tdc_pulse_gen: directed burst table, random bursts against a timeline model,
// and hand sequences for reset, idle abort and back-to-back accept.
module tb_tt_tdc_pulse_gen;

  localparam int CNT_W = 8;
  localparam int PW    = 2;
  localparam int GC    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_delay;
  logic [7:0]       cfg_count;
  logic             abort;
  logic             start_o, stop_o, busy, done;
  logic [7:0]       seq_cnt;

  int vecs = 0;
  int errs = 0;

  tt_tdc_pulse_gen #(.CNT_W(CNT_W), .PULSE_W(PW), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_delay(cfg_delay), .cfg_count(cfg_count), .abort(abort),
    .start_o(start_o), .stop_o(stop_o), .busy(busy), .done(done), .seq_cnt(seq_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start;
    int stop;
    int busy;
    int done;
    int seq;
  } out_t;

  typedef struct {
    int dly;
    int cnt;
    int ab;
    int poke;
    int rst;
    int exp_stop;
    int exp_fall;
    int exp_done;
    int exp_seq;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs after edge e (relative to accept edge 0), from the measurement timeline arithmetic.
  function automatic out_t model(int e, int d, int n_in, int ab);
    out_t o;
    int   n, per, endv, ee;
    bit   aborted;
    o = '{default: 0};
    n = (n_in == 0) ? 1 : n_in;
    per = d + PW + GC;
    endv = 1 + n * per;
    aborted = (ab >= 1) && (e >= ab);
    ee = aborted ? ab - 1 : e;
    for (int m = 0; m < n; m++) begin
      int s;
      s = 1 + m * per;
      if (s + d + PW <= ee) o.seq++;
      if (!aborted) begin
        if (e >= s && e < s + d + PW) o.start = 1;
        if (e >= s + d && e < s + d + PW) o.stop = 1;
      end
    end
    o.busy = (!aborted && e < endv) ? 1 : 0;
    o.done = (!aborted && e == endv) ? 1 : 0;
    return o;
  endfunction

  task automatic run_burst(input int d, input int n, input int ab, input int poke, input int rst_at,
                           output int o_stop, output int o_fall, output int o_done, output int o_seq);
    out_t m;
    int   n_eff, endv, last;
    logic pst, pstp;
    n_eff = (n == 0) ? 1 : n;
    endv  = 1 + n_eff * (d + PW + GC);
    last  = (ab >= 1) ? ab + 2 : endv + 2;
    o_stop = -1; o_fall = -1; o_done = -1; o_seq = -1;
    pst = 1'b0; pstp = 1'b0;
    cfg_delay = CNT_W'(d);
    cfg_count = 8'(n);
    cfg_valid = 1'b1;
    abort     = 1'b0;
    for (int e = 0; e <= last; e++) begin
      @(posedge clk); #1;
      m = model(e, d, n, ab);
      chk("start_o", 32'(start_o), m.start);
      chk("stop_o",  32'(stop_o),  m.stop);
      chk("busy",    32'(busy),    m.busy);
      chk("done",    32'(done),    m.done);
      chk("seq_cnt", 32'(seq_cnt), m.seq);
      if (stop_o && !pstp && o_stop < 0) o_stop = e;
      if (!start_o && pst && o_fall < 0) o_fall = e;
      if (done && o_done < 0) o_done = e;
      pst = start_o; pstp = stop_o; o_seq = int'(seq_cnt);
      if (e == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_start", 32'(start_o), 0);
        chk("rst_stop",  32'(stop_o),  0);
        chk("rst_busy",  32'(busy),    0);
        chk("rst_seq",   32'(seq_cnt), 0);
        @(posedge clk); #1;
        chk("rst_hold_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        o_seq = int'(seq_cnt);
        break;
      end
      abort     = (e + 1 == ab);
      cfg_valid = (e + 1 == poke);
      if (e + 1 == poke) begin
        cfg_delay = 8'($urandom);
        cfg_count = 8'($urandom);
      end
      #1 chk("cfg_ready", 32'(cfg_ready), 32'(m.busy == 0 && !abort));
    end
    cfg_valid = 1'b0;
    abort     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   os, ofl, od, oq;

    tbl.push_back('{5,   1, -1, -1, -1, 6,   8,   12,  1});
    tbl.push_back('{0,   1, -1, -1, -1, 1,   3,   7,   1});
    tbl.push_back('{2,   3, -1, -1, -1, 3,   5,   25,  3});
    tbl.push_back('{10,  2,  4, -1, -1, -1,  4,   -1,  0});
    tbl.push_back('{0,   0, -1,  3, -1, 1,   3,   7,   1});
    tbl.push_back('{3,   1, -1,  2, -1, 4,   6,   10,  1});
    tbl.push_back('{3,   2, -1, -1,  5, 4,   -1,  -1,  0});
    tbl.push_back('{1,   2, -1, -1, -1, 2,   4,   15,  2});
    tbl.push_back('{255, 1, -1, -1, -1, 256, 258, 262, 1});

    rst_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0; cfg_delay = '0; cfg_count = '0;
    #12;
    chk("reset_start", 32'(start_o), 0);
    chk("reset_stop",  32'(stop_o),  0);
    chk("reset_busy",  32'(busy),    0);
    chk("reset_done",  32'(done),    0);
    chk("reset_seq",   32'(seq_cnt), 0);
    chk("reset_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_burst(tbl[i].dly, tbl[i].cnt, tbl[i].ab, tbl[i].poke, tbl[i].rst, os, ofl, od, oq);
      chk($sformatf("tbl%0d_stop_edge", i), os,  tbl[i].exp_stop);
      chk($sformatf("tbl%0d_fall_edge", i), ofl, tbl[i].exp_fall);
      chk($sformatf("tbl%0d_done_edge", i), od,  tbl[i].exp_done);
      chk($sformatf("tbl%0d_seq", i),       oq,  tbl[i].exp_seq);
    end

    // Abort while idle blocks an accept and only masks cfg_ready.
    @(negedge clk);
    abort = 1'b1; cfg_valid = 1'b1; cfg_delay = 8'd3; cfg_count = 8'd1;
    #1 chk("idle_abort_ready", 32'(cfg_ready), 0);
    @(posedge clk); #1;
    chk("idle_abort_busy",  32'(busy),    0);
    chk("idle_abort_start", 32'(start_o), 0);
    abort = 1'b0; cfg_valid = 1'b0;
    #1 chk("idle_abort_ready_after", 32'(cfg_ready), 1);

    // Back-to-back: accept in the done cycle starts the next burst one edge later.
    cfg_delay = 8'd1; cfg_count = 8'd1; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
    end
    chk("b2b_done_seen", 32'(done), 1);
    chk("b2b_ready",     32'(cfg_ready), 1);
    cfg_delay = 8'd0; cfg_count = 8'd1; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    chk("b2b_busy",      32'(busy),    1);
    chk("b2b_start_lat", 32'(start_o), 0);
    chk("b2b_seq_clr",   32'(seq_cnt), 0);
    @(posedge clk); #1;
    chk("b2b_start", 32'(start_o), 1);
    chk("b2b_stop",  32'(stop_o),  1);
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("b2b_idle", 32'(busy), 0);
    chk("b2b_seq",  32'(seq_cnt), 1);
    @(posedge clk); #1;

    for (int r = 0; r < 25; r++) begin
      int d, n, ab, poke, endv;
      d    = ($urandom_range(0, 7) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 12);
      n    = $urandom_range(0, 4);
      endv = 1 + ((n == 0) ? 1 : n) * (d + PW + GC);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, endv) : -1;
      poke = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (ab > 0) ? ab : endv) : -1;
      run_burst(d, n, ab, poke, -1, os, ofl, od, oq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
